// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants and helpers for the event counter
package bcd_pkg;
  localparam int BCD_DIGITS = 3;
  localparam logic [3:0] BCD_ZERO = 4'h0;
  localparam logic [3:0] BCD_NINE = 4'h9;
  function automatic logic [3:0] bcd_sanitise(input logic [3:0] nibble);
    return (nibble > BCD_NINE) ? BCD_NINE : nibble;
  endfunction
  function automatic logic bcd_le(input logic [11:0] a, input logic [11:0] b);
    return a <= b;
  endfunction
endpackage

// File: rtl/bcd_event_counter_digit.sv
// bcd_digit: one decimal digit with load, clear and carry/borrow chaining
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       up,
  input  logic       carry_in,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       clear,
  output logic [3:0] digit,
  output logic       carry_out
);
  assign carry_out = carry_in & (up ? digit == BCD_NINE : digit == BCD_ZERO);
  // digit register: clear beats load beats a chained step
  always_ff @(posedge clk)
    if (reset || clear) digit <= BCD_ZERO;
    else if (load) digit <= load_digit;
    else if (step && carry_in)
      digit <= up ? ((digit == BCD_NINE) ? BCD_ZERO : digit + 4'd1)
                  : ((digit == BCD_ZERO) ? BCD_NINE : digit - 4'd1);
endmodule

// File: rtl/bcd_event_counter.sv
// bcd_event_counter: prescaled 3-digit BCD up/down counter with load, clear and wrap
module bcd_event_counter
  import bcd_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter logic [11:0] MAX_BCD  = 12'h999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        up,
  input  logic        clear,
  input  logic        load,
  input  logic [11:0] load_val,
  output logic [15:0] bcd,
  output logic        tick_out,
  output logic        wrap
);
  localparam logic [25:0] LAST = 26'(TICK_DIV - 1);
  logic [25:0] presc;
  logic [11:0] count, sane, load_word;
  logic [BCD_DIGITS:0] chain;
  logic step_edge, step, wrap_cond;
  assign step_edge = en && presc == LAST;
  // all digits zero while counting down shows up as a full borrow chain
  assign wrap_cond = up ? count == MAX_BCD : chain[BCD_DIGITS];
  assign step = step_edge && !clear && !load;
  assign sane = {bcd_sanitise(load_val[11:8]), bcd_sanitise(load_val[7:4]), bcd_sanitise(load_val[3:0])};
  // wrap steps reuse the digit load path to jump to 000 or the terminal count
  assign load_word = load ? (bcd_le(sane, MAX_BCD) ? sane : MAX_BCD) : (up ? 12'h000 : MAX_BCD);
  assign chain[0] = 1'b1;
  assign bcd = {4'h0, count};
  for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_digit
    bcd_digit u_digit (
      .clk(clk),
      .reset(reset),
      .step(step && !wrap_cond),
      .up(up),
      .carry_in(chain[d]),
      .load(load || (step && wrap_cond)),
      .load_digit(load_word[4*d +: 4]),
      .clear(clear),
      .digit(count[4*d +: 4]),
      .carry_out(chain[d+1])
    );
  end
  // prescaler: free-runs while enabled, restarts on clear or load
  always_ff @(posedge clk)
    if (reset || clear || load) presc <= '0;
    else if (en) presc <= (presc == LAST) ? '0 : presc + 26'd1;
  // one-cycle pulses following a committed step
  always_ff @(posedge clk)
    if (reset) begin
      tick_out <= 1'b0;
      wrap <= 1'b0;
    end else begin
      tick_out <= step;
      wrap <= step && wrap_cond;
    end
endmodule

// File: tb/tb_bcd_event_counter.sv
// tb_bcd_event_counter: randomized and directed check of two counter configurations against a decimal model
module tb_bcd_event_counter;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, up = 1'b1, clear = 1'b0, load = 1'b0;
  logic [11:0] load_val = 12'h000;
  logic [15:0] bcd [2];
  logic tick_out [2], wrap [2];
  int checks = 0, errors = 0;
  int mx [2] = '{999, 59};
  int cnt [2] = '{0, 0};
  int ps [2] = '{0, 0};
  bit m_tick [2] = '{0, 0};
  bit m_wrap [2] = '{0, 0};
  always #5 clk = ~clk;
  bcd_event_counter #(.TICK_DIV(4), .MAX_BCD(12'h999)) u0 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .bcd(bcd[0]), .tick_out(tick_out[0]), .wrap(wrap[0]));
  bcd_event_counter #(.TICK_DIV(4), .MAX_BCD(12'h059)) u1 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .bcd(bcd[1]), .tick_out(tick_out[1]), .wrap(wrap[1]));
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] to_bcd(input int v);
    return {4'h0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  function automatic int clamp(input logic [11:0] v, input int m);
    int h, t, o, r;
    h = (v[11:8] > 9) ? 9 : int'(v[11:8]);
    t = (v[7:4] > 9) ? 9 : int'(v[7:4]);
    o = (v[3:0] > 9) ? 9 : int'(v[3:0]);
    r = h * 100 + t * 10 + o;
    return (r > m) ? m : r;
  endfunction
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      m_tick[i] = 0;
      m_wrap[i] = 0;
      if (reset || clear) begin
        cnt[i] = 0;
        ps[i] = 0;
      end else if (load) begin
        cnt[i] = clamp(load_val, mx[i]);
        ps[i] = 0;
      end else if (en) begin
        if (ps[i] == 3) begin
          ps[i] = 0;
          m_tick[i] = 1;
          if (up) begin
            m_wrap[i] = cnt[i] == mx[i];
            cnt[i] = m_wrap[i] ? 0 : cnt[i] + 1;
          end else begin
            m_wrap[i] = cnt[i] == 0;
            cnt[i] = m_wrap[i] ? mx[i] : cnt[i] - 1;
          end
        end else ps[i] = ps[i] + 1;
      end
    end
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      check($sformatf("bcd%0d", i), bcd[i], to_bcd(cnt[i]));
      check($sformatf("tick%0d", i), {15'h0, tick_out[i]}, {15'h0, m_tick[i]});
      check($sformatf("wrap%0d", i), {15'h0, wrap[i]}, {15'h0, m_wrap[i]});
    end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_load(input logic [11:0] v);
    load_val = v;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask
  initial begin
    cyc(2);
    check("reset_bcd", bcd[0], 16'h0000);
    reset = 1'b0;
    en = 1'b1;
    up = 1'b1;
    cyc(40);
    check("count_40", bcd[0], 16'h0010);
    do_load(12'h998);
    check("load_998", bcd[0], 16'h0998);
    cyc(12);
    up = 1'b0;
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    cyc(5);
    check("down_wrap", bcd[0], 16'h0999);
    do_load(12'h100);
    cyc(4);
    check("double_borrow", bcd[0], 16'h0099);
    do_load(12'hA5F);
    check("sanitise", bcd[0], 16'h0959);
    check("clamp_small", bcd[1], 16'h0059);
    up = 1'b1;
    do_load(12'h123);
    check("clamp_123", bcd[1], 16'h0059);
    cyc(6);
    do_load(12'h042);
    cyc(3);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("clear_on_step", bcd[0], 16'h0000);
    load_val = 12'h555;
    load = 1'b1;
    reset = 1'b1;
    cyc(1);
    check("reset_over_load", bcd[0], 16'h0000);
    reset = 1'b0;
    load = 1'b0;
    cyc(2);
    en = 1'b0;
    cyc(10);
    en = 1'b1;
    cyc(8);
    for (int k = 0; k < 3000; k++) begin
      en = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 15) == 0) up = $urandom_range(0, 1) == 1;
      clear = $urandom_range(0, 199) == 0;
      load = $urandom_range(0, 49) == 0;
      load_val = 12'($urandom_range(0, 4095));
      reset = $urandom_range(0, 999) == 0;
      cyc(1);
    end
    reset = 1'b0;
    clear = 1'b0;
    load = 1'b0;
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_event_counter.md
Name: bcd_event_counter

Overview:
- Three-digit decimal (BCD) up/down counter with a built-in tick prescaler.
- Drives the 16-bit packed-BCD input of the 4-digit seven-segment display controller.
- Digits 0-2 carry the count; nibble [15:12] is always 0 because the display controller renders its fourth digit as a fixed symbol.
- Also provides synchronous clear, parallel load with digit sanitising, a programmable terminal count, and wrap/tick pulses for cascading.

Parameters:
TICK_DIV, 50_000_000, clk cycles per count step (1 s at 50 MHz); legal range 2..2^26
MAX_BCD, 12'h999, terminal count as 3-digit packed BCD; every nibble must be <= 9

Ports:
clk        input   1   system clock, 50 MHz nominal
reset      input   1   synchronous, active-high reset
en         input   1   1 = prescaler runs; 0 = prescaler and count hold
up         input   1   1 = count up, 0 = count down; sampled on the step edge
clear      input   1   synchronous clear of count and prescaler
load       input   1   synchronous parallel load
load_val   input   12  packed BCD load value {hundreds, tens, ones}
bcd        output  16  {4'h0, hundreds, tens, ones} to the display controller
tick_out   output  1   one-cycle pulse after each count step
wrap       output  1   one-cycle pulse after a step that wraps the count

Behaviour:
- Reset (reset=1 at a clk edge):
  - bcd=16'h0000, prescaler=0, tick_out=0, wrap=0.
  - Reset overrides every other input.
- Priority, highest first: reset > clear > load > step > hold.
- Prescaler (26-bit):
  - When en=1, it increments each cycle.
  - When it equals TICK_DIV-1 it returns to 0; that edge is the step edge.
  - When en=0 it holds its value.
- clear:
  - Sets the count to 000 and the prescaler to 0.
  - tick_out and wrap are 0 in the following cycle.
- load:
  - Sanitise each nibble of load_val: any nibble > 9 becomes 9.
  - If the sanitised value > MAX_BCD (compare as a decimal magnitude), load MAX_BCD; otherwise load the sanitised value.
  - Prescaler resets to 0. No tick_out or wrap pulse.
  - load is honoured regardless of en.
- Step with up=1:
  - If count == MAX_BCD: count becomes 000 and wrap is set.
  - Otherwise: ones+1. Ones 9 becomes 0 and carries into tens; tens 9 becomes 0 and carries into hundreds.
- Step with up=0:
  - If count == 000: count becomes MAX_BCD and wrap is set.
  - Otherwise: ones-1. Ones 0 becomes 9 and borrows from tens; tens 0 becomes 9 and borrows from hundreds.
- Latency:
  - bcd updates on the step edge itself.
  - tick_out is registered and high for exactly the one cycle after the step edge; wrap likewise when the step wrapped.
- Simultaneous events:
  - load or clear on a step edge: the step is discarded (no tick_out).
  - Toggling up between steps has no side effect; up is only sampled on the step edge.
- Invariants:
  - Every nibble of bcd is always <= 9.
  - bcd[11:0] <= MAX_BCD.
  - bcd[15:12] == 0.
- en falling mid-period: the prescaler freezes; counting resumes from the frozen value when en returns to 1.

Decomposition:
- Package bcd_pkg:
  - BCD_DIGITS=3.
  - Nibble constants BCD_ZERO=4'h0 and BCD_NINE=4'h9.
  - Function bcd_sanitise(nibble) returning the nibble clamped to 9.
  - Function bcd_le(a,b) for 12-bit packed-BCD magnitude compare.
- Sub-module bcd_digit (one per digit, instantiated 3x):
  - Inputs: step, up, carry_in, load, load_digit, clear.
  - Outputs: digit[3:0], carry_out.
  - carry_out = carry_in & (digit==9 when up, digit==0 when down).
- Top level holds the prescaler, the MAX_BCD terminal/wrap logic, load clamping and the output registers.

Test Plan (TICK_DIV=4, MAX_BCD=12'h999 unless noted):
1. Reset, then en=1, up=1 for 40 cycles -> bcd steps 0000,0001,...,0010 every 4 cycles; tick_out high one cycle after each step; wrap never high.
2. load_val=12'h998, load=1, then up=1 for 2 steps -> 0998, 0999, 0000; wrap high exactly once, the cycle after 0999->0000.
3. Count=000, up=0, one step -> bcd=0999 and wrap pulses. Load 12'h100 then step down -> 0099 (double borrow).
4. load_val=12'hA5F -> bcd=0959. With MAX_BCD=12'h059: load 12'h123 -> 0059; counting up from 059 -> 000 with wrap.
5. Assert clear on a step edge while the count is 0042 -> bcd=0000 next cycle, no tick_out. Assert reset during load -> bcd=0000.
6. en=0 for 10 cycles mid-period, then en=1 -> the next step occurs after the remaining prescaler cycles only; no steps while en=0.
